// File: rtl/alu_stage_sequencer.sv
// Five-stage instruction sequencer with memory-ready stalls and a stall timeout.
// It also steers ALU operands and the op select for each stage, including the branch-offset PC update.
module alu_stage_sequencer #(
    parameter int WIDTH     = 32,
    parameter int OP_W      = 3,
    parameter int OP_ADD    = 3,
    parameter int PC_STEP   = 1,
    parameter int STALL_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             mem_ready,
    input  logic             instr_mem_rd,
    input  logic             instr_mem_wr,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic [WIDTH-1:0] PC_output,
    input  logic [WIDTH-1:0] reg_a,
    input  logic [WIDTH-1:0] reg_b,
    input  logic [OP_W-1:0]  alu_operation,
    output logic [2:0]       stage,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    output logic [OP_W-1:0]  alu_op_select,
    output logic             pc_we,
    output logic             instr_done,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(STALL_MAX + 1);

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_MEM_READ   = 3'd1,
        ST_REG_UPDATE = 3'd2,
        ST_MEM_WRITE  = 3'd3,
        ST_PC_UPDATE  = 3'd4
    } stage_e;

    stage_e           stage_q, stage_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;

    logic             in_wait;
    stage_e           ready_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= ST_FETCH;
            stall_q <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        stage_d    = stage_q;
        stall_d    = stall_q;
        done_d     = 1'b0;
        terr_d     = terr_q;
        in_wait    = 1'b0;
        ready_next = ST_FETCH;

        if (run) begin
            case (stage_q)
                ST_FETCH: begin
                    in_wait    = 1'b1;
                    ready_next = instr_mem_rd ? ST_MEM_READ : ST_REG_UPDATE;
                end
                ST_MEM_READ: begin
                    in_wait    = 1'b1;
                    ready_next = ST_REG_UPDATE;
                end
                ST_MEM_WRITE: begin
                    in_wait    = 1'b1;
                    ready_next = ST_PC_UPDATE;
                end
                ST_REG_UPDATE: begin
                    stage_d = instr_mem_wr ? ST_MEM_WRITE : ST_PC_UPDATE;
                    stall_d = '0;
                end
                ST_PC_UPDATE: begin
                    stage_d = ST_FETCH;
                    stall_d = '0;
                    done_d  = 1'b1;
                end
                default: begin
                    stage_d = ST_FETCH;
                    stall_d = '0;
                end
            endcase

            // mem_ready takes priority over the timeout check on the limit cycle
            if (in_wait) begin
                if (mem_ready) begin
                    stage_d = ready_next;
                    stall_d = '0;
                end else if (stall_q == CNT_W'(STALL_MAX - 1)) begin
                    stage_d = ST_FETCH;
                    stall_d = '0;
                    terr_d  = 1'b1;
                end else if (stall_q != CNT_W'(STALL_MAX)) begin
                    stall_d = stall_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        alu_in0       = reg_a;
        alu_in1       = reg_b;
        alu_op_select = alu_operation;
        pc_we         = 1'b0;
        if (stage_q == ST_PC_UPDATE) begin
            alu_in0       = PC_output;
            alu_in1       = branch_taken ? branch_offset : WIDTH'(PC_STEP);
            alu_op_select = OP_W'(OP_ADD);
            pc_we         = run;
        end
    end

    assign stage       = stage_q;
    assign instr_done  = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_alu_stage_sequencer.sv
// Directed table-driven bench for alu_stage_sequencer (STALL_MAX=4), plus an async-reset sequence.
module tb_alu_stage_sequencer;

    localparam logic [31:0] A  = 32'h0000_00AA;
    localparam logic [31:0] B  = 32'h0000_00BB;
    localparam logic [31:0] P  = 32'h0000_0010;
    localparam logic [31:0] BO = 32'hFFFF_FFFC;
    localparam logic [31:0] BP = 32'hFFFF_FFFE;
    localparam logic [2:0]  OPD = 3'd5;
    localparam int NV = 32;

    logic        clk, rst_n, run, mem_ready, instr_mem_rd, instr_mem_wr, branch_taken;
    logic [31:0] branch_offset, PC_output, reg_a, reg_b;
    logic [2:0]  alu_operation;
    logic [2:0]  stage;
    logic [31:0] alu_in0, alu_in1;
    logic [2:0]  alu_op_select;
    logic        pc_we, instr_done, timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        run, mr, rd, wr, br;
        logic [31:0] off, pc;
        logic [2:0]  stg;
        logic        we, done, terr;
        logic [31:0] in0, in1;
        logic [2:0]  op;
    } vec_t;

    vec_t vecs [NV];

    alu_stage_sequencer #(
        .WIDTH(32), .OP_W(3), .OP_ADD(3), .PC_STEP(1), .STALL_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem_ready(mem_ready),
        .instr_mem_rd(instr_mem_rd), .instr_mem_wr(instr_mem_wr),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .PC_output(PC_output), .reg_a(reg_a), .reg_b(reg_b),
        .alu_operation(alu_operation), .stage(stage), .alu_in0(alu_in0),
        .alu_in1(alu_in1), .alu_op_select(alu_op_select), .pc_we(pc_we),
        .instr_done(instr_done), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input logic r, input logic m, input logic rd, input logic wr,
                                input logic br, input logic [31:0] off, input logic [31:0] pc,
                                input logic [2:0] stg, input logic we, input logic done,
                                input logic terr, input logic [31:0] in0, input logic [31:0] in1,
                                input logic [2:0] op);
        vec_t v;
        v.run = r; v.mr = m; v.rd = rd; v.wr = wr; v.br = br; v.off = off; v.pc = pc;
        v.stg = stg; v.we = we; v.done = done; v.terr = terr; v.in0 = in0; v.in1 = in1; v.op = op;
        return v;
    endfunction

    initial begin
        // ALU-only instruction: 0,2,4,0
        vecs[0]  = mk(1,1,0,0,0,0,P,  3'd0,0,0,0, A,B,OPD);
        vecs[1]  = mk(1,1,0,0,0,0,P,  3'd2,0,0,0, A,B,OPD);
        vecs[2]  = mk(1,1,0,0,0,0,P,  3'd4,1,0,0, P,32'd1,3'd3);
        // Load+store with three not-ready cycles in MEM_READ; ready on the limit cycle wins
        vecs[3]  = mk(1,1,1,1,0,0,P,  3'd0,0,1,0, A,B,OPD);
        vecs[4]  = mk(1,0,1,1,0,0,P,  3'd1,0,0,0, A,B,OPD);
        vecs[5]  = mk(1,0,1,1,0,0,P,  3'd1,0,0,0, A,B,OPD);
        vecs[6]  = mk(1,0,1,1,0,0,P,  3'd1,0,0,0, A,B,OPD);
        vecs[7]  = mk(1,1,1,1,0,0,P,  3'd1,0,0,0, A,B,OPD);
        vecs[8]  = mk(1,1,1,1,0,0,P,  3'd2,0,0,0, A,B,OPD);
        vecs[9]  = mk(1,1,1,1,0,0,P,  3'd3,0,0,0, A,B,OPD);
        vecs[10] = mk(1,1,1,1,0,0,P,  3'd4,1,0,0, P,32'd1,3'd3);
        // Branch with run dropped in PC_UPDATE
        vecs[11] = mk(1,1,0,0,0,0,P,  3'd0,0,1,0, A,B,OPD);
        vecs[12] = mk(1,1,0,0,1,BO,BP, 3'd2,0,0,0, A,B,OPD);
        vecs[13] = mk(0,1,0,0,1,BO,BP, 3'd4,0,0,0, BP,BO,3'd3);
        vecs[14] = mk(0,1,0,0,1,BO,BP, 3'd4,0,0,0, BP,BO,3'd3);
        vecs[15] = mk(1,1,0,0,1,BO,BP, 3'd4,1,0,0, BP,BO,3'd3);
        // Store that times out in MEM_WRITE
        vecs[16] = mk(1,1,0,1,0,0,P,  3'd0,0,1,0, A,B,OPD);
        vecs[17] = mk(1,1,0,1,0,0,P,  3'd2,0,0,0, A,B,OPD);
        vecs[18] = mk(1,0,0,1,0,0,P,  3'd3,0,0,0, A,B,OPD);
        vecs[19] = mk(1,0,0,1,0,0,P,  3'd3,0,0,0, A,B,OPD);
        vecs[20] = mk(1,0,0,1,0,0,P,  3'd3,0,0,0, A,B,OPD);
        vecs[21] = mk(1,0,0,1,0,0,P,  3'd3,0,0,0, A,B,OPD);
        vecs[22] = mk(1,1,0,0,0,0,P,  3'd0,0,0,1, A,B,OPD);
        // Later instruction still sees the sticky error
        vecs[23] = mk(1,1,0,0,0,0,P,  3'd2,0,0,1, A,B,OPD);
        vecs[24] = mk(1,1,0,0,0,0,P,  3'd4,1,0,1, P,32'd1,3'd3);
        // Timeout in FETCH stays in FETCH and restarts the count
        vecs[25] = mk(1,0,0,0,0,0,P,  3'd0,0,1,1, A,B,OPD);
        vecs[26] = mk(1,0,0,0,0,0,P,  3'd0,0,0,1, A,B,OPD);
        vecs[27] = mk(1,0,0,0,0,0,P,  3'd0,0,0,1, A,B,OPD);
        vecs[28] = mk(1,0,0,0,0,0,P,  3'd0,0,0,1, A,B,OPD);
        vecs[29] = mk(1,0,0,0,0,0,P,  3'd0,0,0,1, A,B,OPD);
        vecs[30] = mk(1,1,0,0,0,0,P,  3'd0,0,0,1, A,B,OPD);
        vecs[31] = mk(1,1,0,0,0,0,P,  3'd2,0,0,1, A,B,OPD);

        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; instr_mem_rd = 1'b0; instr_mem_wr = 1'b0;
        branch_taken = 1'b0; branch_offset = '0; PC_output = P;
        reg_a = A; reg_b = B; alu_operation = OPD;
        #1;
        check("rst_stage", -1, {29'd0, stage}, 32'd0);
        check("rst_done",  -1, {31'd0, instr_done}, 32'd0);
        check("rst_terr",  -1, {31'd0, timeout_err}, 32'd0);
        check("rst_pc_we", -1, {31'd0, pc_we}, 32'd0);
        check("rst_in0",   -1, alu_in0, A);
        check("rst_op",    -1, {29'd0, alu_op_select}, {29'd0, OPD});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            run = vecs[i].run; mem_ready = vecs[i].mr; instr_mem_rd = vecs[i].rd;
            instr_mem_wr = vecs[i].wr; branch_taken = vecs[i].br;
            branch_offset = vecs[i].off; PC_output = vecs[i].pc;
            #1;
            check("stage", i, {29'd0, stage}, {29'd0, vecs[i].stg});
            check("pc_we", i, {31'd0, pc_we}, {31'd0, vecs[i].we});
            check("instr_done", i, {31'd0, instr_done}, {31'd0, vecs[i].done});
            check("timeout_err", i, {31'd0, timeout_err}, {31'd0, vecs[i].terr});
            check("alu_in0", i, alu_in0, vecs[i].in0);
            check("alu_in1", i, alu_in1, vecs[i].in1);
            check("alu_op", i, {29'd0, alu_op_select}, {29'd0, vecs[i].op});
        end

        // Async reset while stalled in MEM_WRITE
        @(negedge clk);
        run = 1'b1; mem_ready = 1'b1; instr_mem_rd = 1'b0; instr_mem_wr = 1'b1;
        branch_taken = 1'b0; PC_output = P;
        begin
            bit reached;
            reached = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if (stage == 3'd3) begin
                    reached = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("reach_mem_write", 100, {31'd0, reached}, 32'd1);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("stall_mem_write", 101, {29'd0, stage}, 32'd3);
        check("terr_before_rst", 101, {31'd0, timeout_err}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_stage", 102, {29'd0, stage}, 32'd0);
        check("async_rst_terr",  102, {31'd0, timeout_err}, 32'd0);
        check("async_rst_done",  102, {31'd0, instr_done}, 32'd0);
        check("async_rst_pc_we", 102, {31'd0, pc_we}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_stage", 103, {29'd0, stage}, 32'd0);
        check("post_rst_done",  103, {31'd0, instr_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
